hazard_ctrl_mc: RTL and testbench

Pipeline hazard controller for the 5-stage core. It is the parametrised successor of the single-cycle stall/forward unit. It adds a multi-cycle mul/div occupancy counter, a data-memory wait handshake that freezes the pipe, branch-taken decode flush, per-stage stall/flush outputs and a saturating stall-cycle performance counter. It sits beside the datapath and drives the F/D/E/M/W pipeline register enables and clears, plus the forwarding muxes.

---
 rtl/hazard_ctrl_mc.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: load-use/branch stalls, multi-cycle mul/div occupancy,
// data-memory wait freeze, decode flush on taken branch, forwarding selects and a stall counter.
module hazard_ctrl_mc #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              BranchD,
    input  logic              PCSrcD,
    input  logic              MultDivE,
    input  logic              MemtoRegE,
    input  logic              RegWriteE,
    input  logic              MemtoRegM,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    input  logic              ClrStallCnt,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MDBusy,
    output logic [CNT_W-1:0]  StallCnt
);

    localparam int MDC_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [MDC_W-1:0] MD_LOAD = MDC_W'(MD_LAT - 1);
    localparam logic [MDC_W-1:0] MD_ONE  = MDC_W'(1);

    logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic memwait, mdstall, lwstall, branchstall, dep_stall;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_m, flush_w;

    logic [REG_AW-1:0] src_d [2];
    logic [REG_AW-1:0] src_e [2];
    logic              fwd_d [2];
    logic [1:0]        fwd_e [2];
    logic              hit_e_d [2];
    logic              hit_m_d [2];

    assign src_d[0] = RsD;
    assign src_d[1] = RtD;
    assign src_e[0] = RsE;
    assign src_e[1] = RtE;

    // Per-operand comparisons; operand 0 is Rs, operand 1 is Rt.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign hit_e_d[gi] = (WriteRegE != '0) && (WriteRegE == src_d[gi]);
            assign hit_m_d[gi] = (WriteRegM != '0) && (WriteRegM == src_d[gi]);
            assign fwd_d[gi]   = (src_d[gi] != '0) && RegWriteM && (src_d[gi] == WriteRegM);

            always_comb begin
                fwd_e[gi] = 2'b00;
                if ((src_e[gi] != '0) && RegWriteM && (src_e[gi] == WriteRegM)) begin
                    fwd_e[gi] = 2'b10;
                end else if ((src_e[gi] != '0) && RegWriteW && (src_e[gi] == WriteRegW)) begin
                    fwd_e[gi] = 2'b01;
                end
            end
        end
    endgenerate

    assign memwait     = MemReqM & ~MemReadyM;
    assign mdstall     = MultDivE & (md_cnt_q != MD_ONE);
    assign lwstall     = MemtoRegE & (RtE != '0) & ((RsD == RtE) | (RtD == RtE));
    assign branchstall = BranchD & ((RegWriteE & (hit_e_d[0] | hit_e_d[1])) |
                                    (MemtoRegM & (hit_m_d[0] | hit_m_d[1])));
    assign dep_stall   = (lwstall | branchstall) & ~mdstall & ~memwait;

    always_comb begin
        stall_f = memwait | mdstall | dep_stall;
        stall_d = stall_f;
        stall_e = memwait | mdstall;
        stall_m = memwait;
        flush_w = memwait;
        flush_m = mdstall & ~memwait;
        flush_e = dep_stall;
        // A stalled taken branch must stay in D, so it cannot flush yet.
        flush_d = PCSrcD & ~stall_d & ~memwait;
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (!memwait) begin
            if ((md_cnt_q == '0) && MultDivE) begin
                md_cnt_d = MD_LOAD;
            end else if (md_cnt_q != '0) begin
                md_cnt_d = md_cnt_q - MD_ONE;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ClrStallCnt) begin
            stall_cnt_d = '0;
        end else if (stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Every output is forced low for the whole cycle in which reset is asserted.
    assign StallF    = rst_n & stall_f;
    assign StallD    = rst_n & stall_d;
    assign StallE    = rst_n & stall_e;
    assign StallM    = rst_n & stall_m;
    assign FlushD    = rst_n & flush_d;
    assign FlushE    = rst_n & flush_e;
    assign FlushM    = rst_n & flush_m;
    assign FlushW    = rst_n & flush_w;
    assign ForwardAD = rst_n & fwd_d[0];
    assign ForwardBD = rst_n & fwd_d[1];
    assign ForwardAE = rst_n ? fwd_e[0] : 2'b00;
    assign ForwardBE = rst_n ? fwd_e[1] : 2'b00;
    assign MDBusy    = rst_n & (md_cnt_q != '0);
    assign StallCnt  = rst_n ? stall_cnt_q : '0;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: directed scenarios plus random traffic, checked each cycle
// against a cycle-age model of the mul/div occupancy and an integer stall counter.
module tb_hazard_ctrl_mc;

    localparam int REG_AW = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic BranchD, PCSrcD, MultDivE, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW;
    logic MemReqM, MemReadyM, ClrStallCnt;
    logic [REG_AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
    logic ForwardAD, ForwardBD, MDBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCnt;

    int errors = 0;
    int checks = 0;
    int cycle_no = 0;
    int md_age = 0;     // cycles since the current mul/div op began; 0 = idle
    int stall_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl_mc #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .BranchD(BranchD), .PCSrcD(PCSrcD), .MultDivE(MultDivE),
        .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .MemtoRegM(MemtoRegM),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ClrStallCnt(ClrStallCnt), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .MDBusy(MDBusy), .StallCnt(StallCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d: got %0h expected %0h", tag, cycle_no, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] r);
        if (r != 0 && RegWriteM && r == WriteRegM) return 2'b10;
        if (r != 0 && RegWriteW && r == WriteRegW) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        BranchD = 0; PCSrcD = 0; MultDivE = 0; MemtoRegE = 0; RegWriteE = 0;
        MemtoRegM = 0; RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemReadyM = 0;
        ClrStallCnt = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    endtask

    // Called just after a rising edge with inputs set; checks mid-cycle, then advances the model.
    task automatic cyc();
        bit mw, mds, lw, br, sf, se, fe, fm, fd;
        bit [1:0] fae, fbe;
        bit fad, fbd, busy;
        int cnt_exp;
        #4;
        mw  = MemReqM && !MemReadyM;
        mds = MultDivE && (md_age != MD_LAT - 1);
        lw  = MemtoRegE && RtE != 0 && (RsD == RtE || RtD == RtE);
        br  = BranchD && ((RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                          (MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD)));
        sf  = mw || mds || lw || br;
        se  = mw || mds;
        fm  = mds && !mw;
        fe  = (lw || br) && !mds && !mw;
        fd  = PCSrcD && !sf;
        fad = RsD != 0 && RegWriteM && RsD == WriteRegM;
        fbd = RtD != 0 && RegWriteM && RtD == WriteRegM;
        fae = fwd_sel(RsE);
        fbe = fwd_sel(RtE);
        busy = md_age != 0;
        cnt_exp = stall_cnt;
        if (!rst_n) begin
            sf = 0; se = 0; fm = 0; fe = 0; fd = 0; fad = 0; fbd = 0;
            fae = 0; fbe = 0; busy = 0; mw = 0; cnt_exp = 0;
        end
        $display("cyc %0d rst_n=%b mw=%b md=%b lw=%b br=%b age=%0d cnt=%0d",
                 cycle_no, rst_n, mw, mds, lw, br, md_age, stall_cnt);
        chk("StallF", 32'(StallF), 32'(sf));
        chk("StallD", 32'(StallD), 32'(sf));
        chk("StallE", 32'(StallE), 32'(se));
        chk("StallM", 32'(StallM), 32'(mw));
        chk("FlushD", 32'(FlushD), 32'(fd));
        chk("FlushE", 32'(FlushE), 32'(fe));
        chk("FlushM", 32'(FlushM), 32'(fm));
        chk("FlushW", 32'(FlushW), 32'(mw));
        chk("ForwardAD", 32'(ForwardAD), 32'(fad));
        chk("ForwardBD", 32'(ForwardBD), 32'(fbd));
        chk("ForwardAE", 32'(ForwardAE), 32'(fae));
        chk("ForwardBE", 32'(ForwardBE), 32'(fbe));
        chk("MDBusy", 32'(MDBusy), 32'(busy));
        chk("StallCnt", 32'(StallCnt), 32'(cnt_exp));
        @(posedge clk);
        #1;
        cycle_no++;
        if (!rst_n) begin
            md_age = 0;
            stall_cnt = 0;
        end else begin
            if (!mw) begin
                if (md_age == 0) md_age = MultDivE ? 1 : 0;
                else md_age = (md_age + 1 == MD_LAT) ? 0 : md_age + 1;
            end
            if (ClrStallCnt) stall_cnt = 0;
            else if (sf && stall_cnt < CNT_MAX) stall_cnt++;
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        @(posedge clk);
        #1;
        // Reset with hazards present on the inputs: outputs must still be all zero.
        MemReqM = 1; MultDivE = 1; RsE = 3; WriteRegM = 3; RegWriteM = 1; PCSrcD = 1;
        cyc();
        cyc();
        idle_inputs();
        rst_n = 1;
        cyc();

        // Load-use, then the same pattern on register 0.
        MemtoRegE = 1; RtE = 8; RsD = 8;
        cyc();
        RtE = 0; RsD = 0;
        cyc();
        idle_inputs();

        // Mul/div held for MD_LAT cycles, then idle.
        MultDivE = 1;
        for (int i = 0; i < MD_LAT; i++) cyc();
        MultDivE = 0;
        cyc();
        chk("MDBusy_idle", 32'(MDBusy), 32'd0);

        // Memory wait while the mul/div counter sits at 2.
        MultDivE = 1;
        cyc();
        cyc();
        MemReqM = 1; MemReadyM = 0;
        cyc();
        cyc();
        chk("FlushM_in_wait", 32'(FlushM), 32'd0);
        MemReadyM = 1;
        cyc();
        cyc();
        MultDivE = 0; MemReqM = 0;
        cyc();

        // Branch depending on an E-stage write, then resolved with no hazard.
        BranchD = 1; RegWriteE = 1; WriteRegE = 5; RsD = 5; PCSrcD = 1;
        cyc();
        RegWriteE = 0;
        cyc();
        idle_inputs();

        // Forwarding priority M over W.
        RsE = 3; RtE = 3; WriteRegM = 3; WriteRegW = 3; RegWriteM = 1; RegWriteW = 1;
        cyc();
        RegWriteM = 0;
        cyc();
        idle_inputs();

        // Counter saturation, clear-wins, and reset mid-count.
        ClrStallCnt = 1;
        cyc();
        ClrStallCnt = 0;
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < CNT_MAX + 4; i++) cyc();
        chk("StallCnt_sat", 32'(StallCnt), 32'(CNT_MAX));
        ClrStallCnt = 1;
        cyc();
        chk("StallCnt_clr", 32'(StallCnt), 32'd0);
        ClrStallCnt = 0;
        for (int i = 0; i < 5; i++) cyc();
        rst_n = 0;
        cyc();
        rst_n = 1;
        idle_inputs();
        chk("StallCnt_rst", 32'(StallCnt), 32'd0);
        cyc();

        // Random traffic on a small register window to provoke collisions.
        for (int i = 0; i < 500; i++) begin
            BranchD     = ($urandom_range(0, 3) == 0);
            PCSrcD      = ($urandom_range(0, 3) == 0);
            MultDivE    = ($urandom_range(0, 2) == 0);
            MemtoRegE   = $urandom_range(0, 1);
            RegWriteE   = $urandom_range(0, 1);
            MemtoRegM   = $urandom_range(0, 1);
            RegWriteM   = $urandom_range(0, 1);
            RegWriteW   = $urandom_range(0, 1);
            MemReqM     = $urandom_range(0, 1);
            MemReadyM   = ($urandom_range(0, 2) != 0);
            ClrStallCnt = ($urandom_range(0, 15) == 0);
            RsD = REG_AW'($urandom_range(0, 3)); RtD = REG_AW'($urandom_range(0, 3));
            RsE = REG_AW'($urandom_range(0, 3)); RtE = REG_AW'($urandom_range(0, 3));
            WriteRegE = REG_AW'($urandom_range(0, 3));
            WriteRegM = REG_AW'($urandom_range(0, 3));
            WriteRegW = REG_AW'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 63) != 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
